// File: rtl/karatsuba_seq_mul_ctrl_pkg.sv
// Shared definitions for the sequential karatsuba multiplier controller.
//   CHUNK_W   : width of one operand chunk, tied to the 4x4 core
//   state_t   : controller state encoding
//   chunk_lsb : bit offset of chunk i inside an operand
//   shift_amt : left shift applied to the partial product of chunks (i, j)
package karatsuba_pkg;

  localparam int unsigned CHUNK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic int unsigned chunk_lsb(input int unsigned i);
    return CHUNK_W * i;
  endfunction

  function automatic int unsigned shift_amt(input int unsigned i, input int unsigned j);
    return CHUNK_W * (i + j);
  endfunction

endpackage

// File: rtl/karatsuba_seq_mul_ctrl_mul_4.sv
// karatsuba_mul_4: purely combinational 4x4 -> 8 unsigned multiplier using
// one level of karatsuba decomposition on 2-bit halves.
//   a : 4-bit multiplicand
//   b : 4-bit multiplier
//   p : 8-bit product a*b
module karatsuba_mul_4
  import karatsuba_pkg::*;
(
  input  logic [CHUNK_W-1:0]   a,
  input  logic [CHUNK_W-1:0]   b,
  output logic [2*CHUNK_W-1:0] p
);

  logic [1:0] ah, al, bh, bl;
  logic [2:0] as, bs;
  logic [3:0] z0, z2;
  logic [5:0] zm, z1;

  always_comb begin
    ah = a[3:2];
    al = a[1:0];
    bh = b[3:2];
    bl = b[1:0];
    z2 = {2'b00, ah} * {2'b00, bh};
    z0 = {2'b00, al} * {2'b00, bl};
    as = {1'b0, ah} + {1'b0, al};
    bs = {1'b0, bh} + {1'b0, bl};
    zm = {3'b000, as} * {3'b000, bs};
    // Middle term ah*bl + al*bh recovered from the sum product; never negative.
    z1 = zm - {2'b00, z2} - {2'b00, z0};
    p  = {z2, 4'b0000} + {z1, 2'b00} + {4'b0000, z0};
  end

endmodule

// File: rtl/karatsuba_seq_mul_ctrl.sv
// karatsuba_seq_mul_ctrl: multi-cycle W x W unsigned multiplier. All K*K
// chunk-pair products are sequenced through a single karatsuba_mul_4 core
// and shift-accumulated into a 2W-bit accumulator, one pair per cycle.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake (ready only in IDLE)
//   a, b                 : W-bit unsigned operands
//   abort                : drop the in-flight operation, return to IDLE
//   out_valid/out_ready  : product handshake (valid held until accepted)
//   p                    : 2W-bit product, stable while out_valid
//   busy                 : operation in RUN or DONE
module karatsuba_seq_mul_ctrl
  import karatsuba_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int unsigned CW    = CHUNK_W;
  localparam int unsigned K     = W / CW;
  localparam int unsigned N     = K * K;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t           state, state_nx;
  logic [W-1:0]     a_q, b_q;
  logic [2*W-1:0]   acc, acc_nx, prod_ext;
  logic [IDX_W-1:0] idx;
  logic [CW-1:0]    core_a, core_b;
  logic [2*CW-1:0]  core_p;
  logic             last, accept;
  int unsigned      ci, cj;

  // Chunk selection and accumulation for the current idx.
  always_comb begin
    ci       = 32'(idx) % K;
    cj       = 32'(idx) / K;
    core_a   = CW'(a_q >> chunk_lsb(ci));
    core_b   = CW'(b_q >> chunk_lsb(cj));
    prod_ext = (2*W)'(core_p);
    acc_nx   = acc + (prod_ext << shift_amt(ci, cj));
    last     = (idx == IDX_W'(N - 1));
  end

  karatsuba_mul_4 u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  // Next state and state-decoded outputs. abort outranks every other event,
  // including an operand offer in IDLE and out_ready in DONE.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid && !abort;
        if (accept) state_nx = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (abort)     state_nx = ST_IDLE;
        else if (last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (abort || out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      idx <= '0;
      p   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q <= a;
            b_q <= b;
            acc <= '0;
            idx <= '0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            acc <= '0;
            idx <= '0;
          end else begin
            acc <= acc_nx;
            idx <= idx + IDX_W'(1);
            if (last) p <= acc_nx;
          end
        end
        ST_DONE: begin
          if (abort) acc <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
